gray_count_receiver: RTL and testbench

Destination-side consumer of a Gray-coded counter (e.g. a WIDTH-bit Gray count produced by a counter in another clock domain). Synchronizes the Gray bus into `clk`, decodes it to binary, reports the increment since the previous sample, and flags illegal multi-bit Gray transitions. It sits directly downstream of the Gray counter and feeds binary count/delta to local logic such as FIFO level and rate monitors.

---
 rtl/gray_count_receiver_if.sv | 23 ++
 rtl/gray_count_receiver.sv | 105 ++++++++++
 tb/tb_gray_count_receiver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_count_receiver_if.sv
// Bus between a Gray-count source domain and its destination-side receiver.
// The master side drives the Gray count and clear; the slave side is the receiver.
interface gray_count_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] i_gray_in;
  logic             i_clear;
  logic             o_ready;
  logic [WIDTH-1:0] o_bin_out;
  logic [WIDTH-1:0] o_delta;
  logic             o_update;
  logic             o_gray_err;

  modport master (
    output i_gray_in, i_clear,
    input  o_ready, o_bin_out, o_delta, o_update, o_gray_err
  );

  modport slave (
    input  i_gray_in, i_clear,
    output o_ready, o_bin_out, o_delta, o_update, o_gray_err
  );
endinterface

// File: rtl/gray_count_receiver.sv
// Gray-count receiver: synchronizes an async Gray bus into clk, decodes it to
// binary, reports the increment per accepted sample and flags multi-bit steps.
module gray_count_receiver #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_count_receiver_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  state_t                            r_state;
  logic [CNT_W-1:0]                  r_fill;
  logic [WIDTH-1:0]                  r_prev_gray;
  logic [WIDTH-1:0]                  r_bin;
  logic [WIDTH-1:0]                  r_delta;
  logic                              r_ready;
  logic                              r_update;
  logic                              r_err;

  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_bin;
  logic [WIDTH-1:0]                  w_diff;
  logic                              w_multi;

  // Plain flop chain; stage 0 is the metastability-exposed capture stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_gray_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits at or above i.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
    assign w_bin[gi] = ^w_sync[WIDTH-1:gi];
  end

  // More than one bit set in the difference means an illegal Gray step.
  assign w_diff  = w_sync ^ r_prev_gray;
  assign w_multi = |(w_diff & (w_diff - WIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_fill      <= '0;
      r_prev_gray <= '0;
      r_bin       <= '0;
      r_delta     <= '0;
      r_ready     <= 1'b0;
      r_update    <= 1'b0;
      r_err       <= 1'b0;
    end else if (bus.i_clear) begin
      // Any in-flight transition is folded into the next baseline.
      r_state  <= S_INIT;
      r_fill   <= '0;
      r_ready  <= 1'b0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_fill == CNT_W'(SYNC_STAGES)) begin
            r_prev_gray <= w_sync;
            r_bin       <= w_bin;
            r_delta     <= '0;
            r_ready     <= 1'b1;
            r_state     <= S_TRACK;
          end else begin
            r_fill <= r_fill + CNT_W'(1);
          end
        end
        S_TRACK: begin
          if (w_sync != r_prev_gray) begin
            r_prev_gray <= w_sync;
            r_bin       <= w_bin;
            r_delta     <= w_bin - r_bin;
            r_update    <= 1'b1;
            if (w_multi) begin
              r_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_ready    = r_ready;
  assign bus.o_bin_out  = r_bin;
  assign bus.o_delta    = r_delta;
  assign bus.o_update   = r_update;
  assign bus.o_gray_err = r_err;

endmodule

// File: tb/tb_gray_count_receiver.sv
// Bench for gray_count_receiver: directed vector table, reset corner cases and
// randomized Gray traffic checked against a sample-history reference model.
module tb_gray_count_receiver;
  localparam int unsigned W  = 4;
  localparam int unsigned S  = 2;
  localparam int          SI = S;
  localparam int          M  = 1 << W;

  logic clk = 1'b0;
  logic rst_n;

  gray_count_receiver_if #(.WIDTH(W)) bus ();

  gray_count_receiver #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int clr;
    int rdy;
    int bin;
    int dlt;
    int upd;
    int err;
  } vec_t;

  vec_t tbl[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   bin_of[M];

  // Reference model: the receiver sees the input from S edges ago, baselines
  // on the (S+1)th edge after reset/clear and tracks changes afterwards.
  int   hist[$];
  int   m_age, m_prev, m_bin, m_dlt, m_upd, m_err;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input int rdy, input int bin,
                           input int dlt, input int upd, input int err);
    chk({tag, ".ready"},    idx, int'(bus.o_ready),    rdy);
    chk({tag, ".bin_out"},  idx, int'(bus.o_bin_out),  bin);
    chk({tag, ".delta"},    idx, int'(bus.o_delta),    dlt);
    chk({tag, ".update"},   idx, int'(bus.o_update),   upd);
    chk({tag, ".gray_err"}, idx, int'(bus.o_gray_err), err);
  endtask

  task automatic add_n(input int n, input int g, input int clr, input int rdy,
                       input int bin, input int dlt, input int upd, input int err);
    vec_t v;
    v.g = g; v.clr = clr; v.rdy = rdy; v.bin = bin; v.dlt = dlt; v.upd = upd; v.err = err;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SI; i++) hist.push_back(0);
    m_age = 0; m_prev = 0; m_bin = 0; m_dlt = 0; m_upd = 0; m_err = 0;
  endtask

  task automatic model_step(input int g, input int clr);
    int s;
    int nb;
    s = hist.pop_front();
    hist.push_back(g);
    m_upd = 0;
    if (clr != 0) begin
      m_age = 0;
      m_err = 0;
    end else begin
      m_age++;
      if (m_age == SI + 1) begin
        m_prev = s;
        m_bin  = bin_of[s];
        m_dlt  = 0;
      end else if (m_age > SI + 1 && s != m_prev) begin
        nb    = bin_of[s];
        m_dlt = (nb - m_bin + M) % M;
        m_bin = nb;
        m_upd = 1;
        if ($countones(s ^ m_prev) > 1) m_err = 1;
        m_prev = s;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, clr, cur, since;

    for (int b = 0; b < M; b++) bin_of[b ^ (b >> 1)] = b;

    //    n  gray clr rdy bin dlt upd err
    add_n(2, 4'h0, 0, 0,  0,  0, 0, 0);
    add_n(2, 4'h0, 0, 1,  0,  0, 0, 0);
    add_n(2, 4'h1, 0, 1,  0,  0, 0, 0);
    add_n(1, 4'h1, 0, 1,  1,  1, 1, 0);
    add_n(1, 4'h1, 0, 1,  1,  1, 0, 0);
    add_n(2, 4'h3, 0, 1,  1,  1, 0, 0);
    add_n(1, 4'h3, 0, 1,  2,  1, 1, 0);
    add_n(1, 4'h3, 0, 1,  2,  1, 0, 0);
    add_n(2, 4'h2, 0, 1,  2,  1, 0, 0);
    add_n(1, 4'h2, 0, 1,  3,  1, 1, 0);
    add_n(1, 4'h2, 0, 1,  3,  1, 0, 0);
    // re-baseline at 1001 (bin 14), then wrap through 15 to 0
    add_n(1, 4'h9, 1, 0,  3,  1, 0, 0);
    add_n(2, 4'h9, 0, 0,  3,  1, 0, 0);
    add_n(1, 4'h9, 0, 1, 14,  0, 0, 0);
    add_n(2, 4'h8, 0, 1, 14,  0, 0, 0);
    add_n(1, 4'h8, 0, 1, 15,  1, 1, 0);
    add_n(1, 4'h8, 0, 1, 15,  1, 0, 0);
    add_n(2, 4'h0, 0, 1, 15,  1, 0, 0);
    add_n(1, 4'h0, 0, 1,  0,  1, 1, 0);
    add_n(1, 4'h0, 0, 1,  0,  1, 0, 0);
    // illegal 0000 -> 0011, then legal steps with sticky error
    add_n(2, 4'h3, 0, 1,  0,  1, 0, 0);
    add_n(1, 4'h3, 0, 1,  2,  2, 1, 1);
    add_n(1, 4'h3, 0, 1,  2,  2, 0, 1);
    add_n(2, 4'h1, 0, 1,  2,  2, 0, 1);
    add_n(1, 4'h1, 0, 1,  1, 15, 1, 1);
    add_n(1, 4'h1, 0, 1,  1, 15, 0, 1);
    add_n(2, 4'h3, 0, 1,  1, 15, 0, 1);
    add_n(1, 4'h3, 0, 1,  2,  1, 1, 1);
    add_n(1, 4'h3, 0, 1,  2,  1, 0, 1);
    // clear while in error with the input stepping 0011 -> 0010 together
    add_n(1, 4'h2, 1, 0,  2,  1, 0, 0);
    add_n(2, 4'h2, 0, 0,  2,  1, 0, 0);
    add_n(2, 4'h2, 0, 1,  3,  0, 0, 0);

    rst_n = 1'b0;
    bus.i_gray_in = '0;
    bus.i_clear   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus.i_gray_in = W'(tbl[i].g);
      bus.i_clear   = (tbl[i].clr != 0);
      @(posedge clk);
      #1;
      check_all("vec", i, tbl[i].rdy, tbl[i].bin, tbl[i].dlt, tbl[i].upd, tbl[i].err);
    end

    // async reset mid-TRACK with the input parked at 0110 (bin 4)
    bus.i_gray_in = 4'b0110;
    bus.i_clear   = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_all("pre_rst", 0, 1, 4, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check_all("post_rst", e, (e >= 3) ? 1 : 0, (e >= 3) ? 4 : 0, 0, 0, 0);
    end

    // randomized traffic against the reference model
    rst_n = 1'b0;
    bus.i_gray_in = '0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur   = 0;
    since = 0;
    for (int c = 0; c < 2000; c++) begin
      r = int'($urandom_range(99));
      since++;
      if (since >= 2 && r < 40) begin
        cur   = (r < 34) ? (cur + 1) % M : (cur + M - 1) % M;
        since = 0;
      end else if (r >= 97) begin
        cur   = int'($urandom_range(M - 1));
        since = 0;
      end
      g   = cur ^ (cur >> 1);
      clr = ($urandom_range(99) < 2) ? 1 : 0;
      bus.i_gray_in = W'(g);
      bus.i_clear   = (clr != 0);
      @(posedge clk);
      model_step(g, clr);
      #1;
      check_all("rnd", c, (m_age >= SI + 1) ? 1 : 0, m_bin, m_dlt, m_upd, m_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
